// File: rtl/pooling_ctrl.sv
// rtl/pooling_ctrl.sv - window sequencer for the max-pooling cell array
module pooling_ctrl #(
  parameter int POOL_SIZE    = 2,
  parameter int OUT_MAP_SIZE = 3,
  parameter int OUTPUT_SIZE  = 3,
  localparam int WIN_LEN  = POOL_SIZE * POOL_SIZE,
  localparam int NUM_WIN  = OUT_MAP_SIZE * OUT_MAP_SIZE,
  localparam int SAMPLE_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1,
  localparam int WIN_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cell_en,
  output logic             cell_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIN_W-1:0] win_idx,
  output logic             out_last
);

  if (WIN_LEN < 1 || WIN_LEN > 8 || NUM_WIN < 1 || OUTPUT_SIZE < 1) begin : g_bad_cfg
    $error("pooling_ctrl: illegal window/map/lane configuration");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic                last_sample;
  logic                last_win;
  logic                handshake;

  assign last_sample = (sample_cnt == SAMPLE_W'(WIN_LEN - 1));
  assign last_win    = (win_cnt == WIN_W'(NUM_WIN - 1));
  assign handshake   = (state == HOLD) && out_ready;

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    cell_en   = 1'b0;
    cell_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cell_en   = 1'b1;
          cell_load = (sample_cnt == '0);
          if (last_sample) state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_n = last_win ? IDLE : ACCUM;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      win_cnt    <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      // HOLD is entered the cycle after the last sample, matching the cell register latency
      out_valid <= (state_n == HOLD);
      done      <= handshake && last_win;
      case (state)
        IDLE: begin
          if (start) begin
            sample_cnt <= '0;
            win_cnt    <= '0;
          end
        end
        ACCUM: begin
          if (cell_en) sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
        end
        HOLD: begin
          if (out_ready) win_cnt <= last_win ? '0 : win_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign win_idx  = win_cnt;
  assign out_last = out_valid && last_win;

endmodule

// File: tb/tb_pooling_ctrl.sv
// tb/tb_pooling_ctrl.sv - directed-vector bench for pooling_ctrl
module tb_pooling_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid, out_ready;
  logic       busy, done, in_ready, cell_en, cell_load, out_valid, out_last;
  logic [3:0] win_idx;
  logic       start1, in_valid1, out_ready1;
  logic       busy1, done1, in_ready1, cell_en1, cell_load1, out_valid1, out_last1;
  logic [1:0] win_idx1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pooling_ctrl #(.POOL_SIZE(2), .OUT_MAP_SIZE(3), .OUTPUT_SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .cell_en(cell_en), .cell_load(cell_load),
    .out_valid(out_valid), .out_ready(out_ready), .win_idx(win_idx), .out_last(out_last)
  );

  pooling_ctrl #(.POOL_SIZE(1), .OUT_MAP_SIZE(2), .OUTPUT_SIZE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .in_valid(in_valid1), .in_ready(in_ready1), .cell_en(cell_en1), .cell_load(cell_load1),
    .out_valid(out_valid1), .out_ready(out_ready1), .win_idx(win_idx1), .out_last(out_last1)
  );

  // {busy, done, in_ready, cell_en, cell_load, out_valid, out_last, win_idx}
  wire [10:0] obs  = {busy, done, in_ready, cell_en, cell_load, out_valid, out_last, win_idx};
  wire [8:0]  obs1 = {busy1, done1, in_ready1, cell_en1, cell_load1, out_valid1, out_last1, win_idx1};

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (obs !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_main: got %b expected %b", obs, 11'h0);
    end
    vectors++;
    if (obs1 !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_small: got %b expected %b", obs1, 9'h0);
    end
  endtask

  task automatic test_default_map();
    logic [10:0] exp;
    int w, p;
    do_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    vectors++;
    if (obs !== 11'h0) begin
      miscompares++;
      $display("FAIL default_start_cycle: got %b expected %b", obs, 11'h0);
    end
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      w = (c - 1) / 5;
      p = (c - 1) % 5;
      if (p < 4) exp = {1'b1, 1'b0, 1'b1, 1'b1, (p == 0), 1'b0, 1'b0, 4'(w)};
      else       exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (w == 8), 4'(w)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL default_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (obs !== 11'b01000000000) begin
      miscompares++;
      $display("FAIL default_done: got %b expected %b", obs, 11'b01000000000);
    end
    @(negedge clk); #1;
    vectors++;
    if (obs !== 11'h0) begin
      miscompares++;
      $display("FAIL default_after_done: got %b expected %b", obs, 11'h0);
    end
  endtask

  task automatic test_toggle_valid();
    logic [10:0] exp;
    do_reset();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = c[0];
      #1;
      if (c <= 7)      exp = {1'b1, 1'b0, 1'b1, c[0], (c == 1), 1'b0, 1'b0, 4'd0};
      else if (c == 8) exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
      else             exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL toggle_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [10:0] exp;
    do_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = (c >= 10);
      #1;
      if (c <= 4)       exp = {1'b1, 1'b0, 1'b1, 1'b1, (c == 1), 1'b0, 1'b0, 4'd0};
      else if (c <= 10) exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
      else              exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [10:0] exp;
    do_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 2) || (c == 6);
      out_ready = (c >= 7);
      #1;
      if (c <= 4)      exp = {1'b1, 1'b0, 1'b1, 1'b1, (c == 1), 1'b0, 1'b0, 4'd0};
      else if (c <= 7) exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
      else             exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL start_ignored_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    #1;
    vectors++;
    if (obs !== 11'b01000000000) begin
      miscompares++;
      $display("FAIL b2b_done: got %b expected %b", obs, 11'b01000000000);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (obs !== 11'b10111000000) begin
      miscompares++;
      $display("FAIL b2b_restart: got %b expected %b", obs, 11'b10111000000);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    vectors++;
    if (obs !== 11'b10110000100) begin
      miscompares++;
      $display("FAIL areset_pre: got %b expected %b", obs, 11'b10110000100);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 11'h0) begin
      miscompares++;
      $display("FAIL areset_immediate: got %b expected %b", obs, 11'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (obs !== 11'b10111000000) begin
      miscompares++;
      $display("FAIL areset_restart: got %b expected %b", obs, 11'b10111000000);
    end
  endtask

  task automatic test_win_len_one();
    logic [8:0] exp;
    do_reset();
    @(negedge clk);
    start1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      if (c == 9)     exp = {1'b0, 1'b1, 7'b0};
      else if (c[0])  exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'((c - 1) / 2)};
      else            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (c == 8), 2'((c - 1) / 2)};
      vectors++;
      if (obs1 !== exp) begin
        miscompares++;
        $display("FAIL win_len1_cycle%0d: got %b expected %b", c, obs1, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_map();
    test_toggle_valid();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_win_len_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
